temp_sampler: RTL

TEMP_SAMPLER -- requirements
Module: temp_sampler

---
 rtl/temp_pkg.sv | 23 ++
 rtl/temp_convert.sv | 29 ++
 rtl/temp_sampler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/temp_pkg.sv
// Shared constants, FSM state type and window-size clamp for the temperature sampler.
// Optional spike rejection is enabled with TEMP_SAMPLER_SPIKE_REJECT_EN.
package temp_pkg;

    localparam int ADC_W    = 12;
    localparam int T_W      = 8;
    localparam int ACC_W    = 16;
    localparam int MAX_LOG2 = 4;
    localparam int CNT_W    = 5;
    localparam int REJ_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        CONV,
        EMIT
    } state_e;

    function automatic logic [2:0] clamp_log2(input logic [2:0] l);
        return (l > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : l;
    endfunction

endpackage

// File: rtl/temp_convert.sv
// Combinational window-average to signed temperature code: shift, subtract offset,
// arithmetic divide by 16 and saturate. Unaffected by TEMP_SAMPLER_SPIKE_REJECT_EN.
module temp_convert
    import temp_pkg::*;
(
    input  logic        [ACC_W-1:0] acc,
    input  logic        [2:0]       log2,
    input  logic signed [ADC_W-1:0] offset,
    output logic signed [T_W-1:0]   t_code
);

    logic        [ACC_W-1:0] avg;
    logic signed [ACC_W:0]   diff;
    logic signed [ACC_W:0]   code;

    // Average never exceeds 4095, so the wider diff matches a 14-bit result exactly.
    always_comb begin
        avg  = acc >> log2;
        diff = $signed({1'b0, avg}) - $signed({{(ACC_W+1-ADC_W){offset[ADC_W-1]}}, offset});
        code = diff >>> 4;
        if (code > 17'sd127)
            t_code = 8'sd127;
        else if (code < -17'sd128)
            t_code = -8'sd128;
        else
            t_code = code[T_W-1:0];
    end

endmodule

// File: rtl/temp_sampler.sv
// ADC windowed averager feeding a calibrated temperature strobe to the estimator.
// Define TEMP_SAMPLER_SPIKE_REJECT_EN to add spike_thr / reject_cnt outlier rejection.
module temp_sampler
    import temp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic        [ADC_W-1:0] adc_data,
    input  logic                    adc_valid,
    output logic                    adc_ready,
    input  logic        [2:0]       avg_log2,
    input  logic signed [ADC_W-1:0] offset,
`ifdef TEMP_SAMPLER_SPIKE_REJECT_EN
    input  logic        [ADC_W-1:0] spike_thr,
    output logic        [REJ_W-1:0] reject_cnt,
`endif
    output logic signed [T_W-1:0]   T_cur,
    output logic                    t_valid,
    output logic                    init
);

    state_e                  state_q;
    logic        [ACC_W-1:0] acc_q, acc_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic        [2:0]       log2_q;
    logic                    first_q;
    logic signed [T_W-1:0]   t_cur_q;
    logic                    t_valid_q, init_q, adc_ready_q;
    logic                    xfer, accept, win_done;
    logic signed [T_W-1:0]   t_code;

`ifdef TEMP_SAMPLER_SPIKE_REJECT_EN
    logic [ADC_W-1:0] last_q;
    logic             have_last_q;
    logic [REJ_W-1:0] reject_cnt_q;
    logic [ADC_W-1:0] delta;
`endif

    temp_convert u_convert (
        .acc    (acc_q),
        .log2   (log2_q),
        .offset (offset),
        .t_code (t_code)
    );

    always_comb begin
        xfer     = adc_valid && adc_ready_q;
        acc_d    = acc_q + ACC_W'(adc_data);
        cnt_d    = cnt_q + CNT_W'(1);
        win_done = (cnt_d == (CNT_W'(1) << log2_q));
`ifdef TEMP_SAMPLER_SPIKE_REJECT_EN
        delta  = (adc_data >= last_q) ? (adc_data - last_q) : (last_q - adc_data);
        accept = !have_last_q || (delta <= spike_thr);
`else
        accept = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            log2_q      <= '0;
            first_q     <= 1'b1;
            t_cur_q     <= '0;
            t_valid_q   <= 1'b0;
            init_q      <= 1'b0;
            adc_ready_q <= 1'b0;
`ifdef TEMP_SAMPLER_SPIKE_REJECT_EN
            last_q       <= '0;
            have_last_q  <= 1'b0;
            reject_cnt_q <= '0;
`endif
        end else if (!enable) begin
            // Dropping enable discards any partial window and never emits.
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            t_valid_q   <= 1'b0;
            init_q      <= 1'b0;
            adc_ready_q <= 1'b0;
`ifdef TEMP_SAMPLER_SPIKE_REJECT_EN
            have_last_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    first_q     <= 1'b1;
                    log2_q      <= clamp_log2(avg_log2);
                    adc_ready_q <= 1'b1;
                    state_q     <= ACCUM;
                end
                ACCUM: begin
                    if (xfer) begin
                        if (accept) begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_d;
                            if (win_done) begin
                                adc_ready_q <= 1'b0;
                                state_q     <= CONV;
                            end
                        end
`ifdef TEMP_SAMPLER_SPIKE_REJECT_EN
                        if (accept) begin
                            last_q      <= adc_data;
                            have_last_q <= 1'b1;
                        end else if (reject_cnt_q != '1) begin
                            reject_cnt_q <= reject_cnt_q + REJ_W'(1);
                        end
`endif
                    end
                end
                CONV: begin
                    t_cur_q   <= t_code;
                    t_valid_q <= 1'b1;
                    init_q    <= first_q;
                    state_q   <= EMIT;
                end
                EMIT: begin
                    t_valid_q   <= 1'b0;
                    init_q      <= 1'b0;
                    first_q     <= 1'b0;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    log2_q      <= clamp_log2(avg_log2);
                    adc_ready_q <= 1'b1;
                    state_q     <= ACCUM;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign adc_ready = adc_ready_q;
    assign T_cur     = t_cur_q;
    assign t_valid   = t_valid_q;
    assign init      = init_q;
`ifdef TEMP_SAMPLER_SPIKE_REJECT_EN
    assign reject_cnt = reject_cnt_q;
`endif

endmodule
